interrupt_acknowledge_sequencer: RTL and testbench
==================================================

INTERRUPT_ACKNOWLEDGE_SEQUENCER -- requirements
Module: interrupt_acknowledge_sequencer

Interface
REQ-001 The block SHALL have the port: clock  in  1  system clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port: reset  in  1  synchronous, active-high reset.
REQ-003 The block SHALL have the port: write_initial_command_word_1  in  1  ICW1 write strobe; aborts the sequence.
REQ-004 The block SHALL have the port: interrupt_acknowledge_n  in  1  INTA# pin, active low, already synchronous to clock.
REQ-005 The block SHALL have the port: u8086_or_mcs80_config  in  1  1 = 8086 mode (2 INTA pulses), 0 = MCS-80 mode (3 INTA pulses).
REQ-006 The block SHALL have the port: interrupt  in  8  one-hot winning request from the priority resolver; 0 = none.
REQ-007 The block SHALL have the port: end_of_interrupt  in  8  ISR clear mask from the OCW2 stage.
REQ-008 The block SHALL have the port: priority_rotate  in  3  lowest-priority level; level priority_rotate+1 (mod 8) is highest.
REQ-009 The block SHALL have the port: interrupt_vector_base  in  5  ICW2 T7-T3 (8086 vector).
REQ-010 The block SHALL have the port: call_address_low  in  3  ICW1 A7-A5 (MCS-80 CALL low byte).
REQ-011 The block SHALL have the port: call_address_high  in  8  ICW2 A15-A8 (MCS-80 CALL high byte).
REQ-012 The block SHALL have the port: interrupt_to_cpu  out  1  INT pin.
REQ-013 The block SHALL have the port: acknowledge_interrupt  out  8  one-hot level latched at the first INTA.
REQ-014 The block SHALL have the port: end_of_acknowledge_sequence  out  1  one-cycle pulse when the sequence completes.
REQ-015 The block SHALL have the port: in_service_register  out  8  ISR.
REQ-016 The block SHALL have the port: highest_level_in_service  out  8  one-hot highest-priority ISR bit under the rotation; 0 if the ISR is empty.
REQ-017 The block SHALL have the port: out_control_logic_data  out  1  data-bus drive enable.
REQ-018 The block SHALL have the port: control_logic_data  out  8  data-bus byte.

Function
REQ-019 Falling and rising INTA edges SHALL be detected from a registered copy of interrupt_acknowledge_n, one cycle after the pin changes.
REQ-020 The FSM SHALL have the states IDLE, ACK1, ACK2 and ACK3, where ACK3 is used in MCS-80 mode only.
REQ-021 In IDLE, interrupt_to_cpu SHALL be registered as (interrupt != 0); it SHALL drop on the first falling edge and stay low until the FSM returns to IDLE.
REQ-022 On a falling edge in IDLE, the block SHALL latch interrupt into acknowledge_interrupt, OR it into the ISR the same cycle, and move to ACK1.
REQ-023 A falling edge in ACK1 SHALL move the FSM to ACK2; in MCS-80 mode, a falling edge in ACK2 SHALL move it to ACK3.
REQ-024 In 8086 mode, the rising edge ending ACK2 SHALL pulse end_of_acknowledge_sequence for one cycle and return the FSM to IDLE.
REQ-025 In MCS-80 mode, the rising edge ending ACK3 SHALL pulse end_of_acknowledge_sequence for one cycle and return the FSM to IDLE.
REQ-026 out_control_logic_data SHALL be 1 only while INTA is low in a data-bearing pulse: 8086 pulse 2; MCS-80 pulses 1, 2 and 3.
REQ-027 Data bytes SHALL be: 8086 pulse 2 = {interrupt_vector_base, level[2:0]}.
REQ-028 MCS-80 data bytes SHALL be: pulse 1 = 8'hCD; pulse 2 = {call_address_low, level[2:0], 2'b00}; pulse 3 = call_address_high.
REQ-029 control_logic_data SHALL be 8'h00 whenever it is not being driven.
REQ-030 The ISR next value SHALL be (ISR | set_mask) & ~end_of_interrupt, so a clear wins over a set on the same bit in the same cycle.
REQ-031 highest_level_in_service SHALL be combinational from the ISR and priority_rotate, scanning from level priority_rotate+1 upward with wrap-around from 7 to 0.
REQ-032 write_initial_command_word_1 SHALL force the FSM to IDLE and clear interrupt_to_cpu and acknowledge_interrupt in the same cycle, with no end_of_acknowledge_sequence pulse.
REQ-033 A falling edge arriving while the FSM is already advancing SHALL be handled by the current state only; extra pulses after completion SHALL start a new sequence from IDLE.
REQ-034 A change of u8086_or_mcs80_config mid-sequence SHALL take effect from the next state transition.

Reset
REQ-035 On reset the FSM SHALL go to IDLE and the registered INTA copy SHALL be set to 1.
REQ-036 On reset interrupt_to_cpu, end_of_acknowledge_sequence and out_control_logic_data SHALL be 0.
REQ-037 On reset acknowledge_interrupt, in_service_register and control_logic_data SHALL be 8'h00.
REQ-038 Reset asserted mid-sequence SHALL abort the sequence with no end_of_acknowledge_sequence pulse.

Configuration
REQ-039 The macro PIC_SPURIOUS_IRQ7_EN SHALL control spurious-interrupt handling.
REQ-040 With PIC_SPURIOUS_IRQ7_EN defined, a first INTA with interrupt == 0 SHALL run a full sequence using level 7 for the vector bytes, leave the ISR unchanged, and set acknowledge_interrupt = 8'h00.
REQ-041 Without PIC_SPURIOUS_IRQ7_EN defined, a first INTA with interrupt == 0 SHALL be ignored: the FSM stays in IDLE and nothing is driven.

Verification
REQ-042 The bench SHALL cover: 8086 mode, interrupt = 8'h08, base = 5'h10, two INTA pulses -> ISR = 8'h08, byte 8'h83 on pulse 2, one end_of_acknowledge_sequence pulse.
REQ-043 The bench SHALL cover: MCS-80 mode, interrupt = 8'h04, call_address_low = 3'b101, call_address_high = 8'h12 -> bytes 8'hCD, 8'hA8, 8'h12.
REQ-044 The bench SHALL cover: ISR = 8'h81, priority_rotate = 3'd6 -> highest_level_in_service = 8'h80; with priority_rotate = 3'd7 -> 8'h01.
REQ-045 The bench SHALL cover: end_of_interrupt = 8'h08 in the same cycle as set 8'h08 -> ISR bit 3 = 0.
REQ-046 The bench SHALL cover: ICW1 write between pulses 1 and 2 -> FSM in IDLE, out_control_logic_data = 0, no end pulse.
REQ-047 The bench SHALL cover: interrupt = 0 at the first INTA in 8086 mode with base = 5'h10 -> with the macro, byte 8'h87 and ISR unchanged; without the macro, no drive.

Source files
------------

// File: rtl/interrupt_acknowledge_sequencer.sv
// rtl/interrupt_acknowledge_sequencer.sv - INTA cycle sequencer, ISR and vector/CALL byte generation.
// Optional spurious IRQ7 handling is enabled by defining PIC_SPURIOUS_IRQ7_EN.
module interrupt_acknowledge_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_initial_command_word_1,
    input  logic       interrupt_acknowledge_n,
    input  logic       u8086_or_mcs80_config,
    input  logic [7:0] interrupt,
    input  logic [7:0] end_of_interrupt,
    input  logic [2:0] priority_rotate,
    input  logic [4:0] interrupt_vector_base,
    input  logic [2:0] call_address_low,
    input  logic [7:0] call_address_high,
    output logic       interrupt_to_cpu,
    output logic [7:0] acknowledge_interrupt,
    output logic       end_of_acknowledge_sequence,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic       out_control_logic_data,
    output logic [7:0] control_logic_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2,
        ACK3 = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       inta_q;
    logic       falling;
    logic       rising;
    logic       start;
    logic       start_ok;
    logic       finish;
    logic [2:0] level_q;
    logic [2:0] start_level;
    logic [7:0] set_mask;
    logic       drive_next;
    logic [7:0] data_next;

    assign falling = inta_q & ~interrupt_acknowledge_n;
    assign rising  = ~inta_q & interrupt_acknowledge_n;

    function automatic logic [2:0] encode(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // A request of zero only gets here with spurious handling, and then reports level 7.
    assign start_level = (interrupt != 8'h00) ? encode(interrupt) : 3'd7;
    assign set_mask    = start ? interrupt : 8'h00;

    always_comb begin
        next_state = state;
        start      = 1'b0;
        finish     = 1'b0;
`ifdef PIC_SPURIOUS_IRQ7_EN
        start_ok   = 1'b1;
`else
        start_ok   = (interrupt != 8'h00);
`endif
        case (state)
            IDLE: begin
                if (falling && start_ok) begin
                    next_state = ACK1;
                    start      = 1'b1;
                end
            end
            ACK1: begin
                if (falling) next_state = ACK2;
            end
            ACK2: begin
                if (u8086_or_mcs80_config && rising) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end else if (!u8086_or_mcs80_config && falling) begin
                    next_state = ACK3;
                end
            end
            ACK3: begin
                if (rising) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (write_initial_command_word_1) begin
            next_state = IDLE;
            start      = 1'b0;
            finish     = 1'b0;
        end
    end

    // Bus drive follows the state being entered so each byte appears with its pulse.
    always_comb begin
        drive_next = 1'b0;
        data_next  = 8'h00;
        if (!interrupt_acknowledge_n) begin
            case (next_state)
                ACK1: begin
                    if (!u8086_or_mcs80_config) begin
                        drive_next = 1'b1;
                        data_next  = 8'hCD;
                    end
                end
                ACK2: begin
                    drive_next = 1'b1;
                    if (u8086_or_mcs80_config) data_next = {interrupt_vector_base, level_q};
                    else                       data_next = {call_address_low, level_q, 2'b00};
                end
                ACK3: begin
                    if (!u8086_or_mcs80_config) begin
                        drive_next = 1'b1;
                        data_next  = call_address_high;
                    end
                end
                default: begin
                    drive_next = 1'b0;
                    data_next  = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                       <= IDLE;
            inta_q                      <= 1'b1;
            interrupt_to_cpu            <= 1'b0;
            acknowledge_interrupt       <= 8'h00;
            level_q                     <= 3'd0;
            end_of_acknowledge_sequence <= 1'b0;
            in_service_register         <= 8'h00;
            out_control_logic_data      <= 1'b0;
            control_logic_data          <= 8'h00;
        end else begin
            state                       <= next_state;
            inta_q                      <= interrupt_acknowledge_n;
            end_of_acknowledge_sequence <= finish;
            out_control_logic_data      <= drive_next;
            control_logic_data          <= data_next;
            in_service_register         <= (in_service_register | set_mask) & ~end_of_interrupt;
            if (write_initial_command_word_1) begin
                interrupt_to_cpu      <= 1'b0;
                acknowledge_interrupt <= 8'h00;
            end else if (start) begin
                interrupt_to_cpu      <= 1'b0;
                acknowledge_interrupt <= interrupt;
                level_q               <= start_level;
            end else begin
                interrupt_to_cpu      <= (state == IDLE) && (interrupt != 8'h00);
            end
        end
    end

    // Walk from the lowest priority down to the highest so the highest set level wins.
    always_comb begin
        logic [2:0] idx;
        highest_level_in_service = 8'h00;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = priority_rotate + 3'd1 + 3'(i);
            if (in_service_register[idx]) highest_level_in_service = 8'h01 << idx;
        end
    end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// tb/tb_interrupt_acknowledge_sequencer.sv - scoreboard bench for interrupt_acknowledge_sequencer.
module tb_interrupt_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       write_initial_command_word_1;
    logic       interrupt_acknowledge_n;
    logic       u8086_or_mcs80_config;
    logic [7:0] interrupt;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic [4:0] interrupt_vector_base;
    logic [2:0] call_address_low;
    logic [7:0] call_address_high;
    logic       interrupt_to_cpu;
    logic [7:0] acknowledge_interrupt;
    logic       end_of_acknowledge_sequence;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic       out_control_logic_data;
    logic [7:0] control_logic_data;

    int         vectors     = 0;
    int         miscompares = 0;
    int         eoa_count   = 0;
    int         drive_count = 0;
    logic       drive_prev  = 1'b0;
    logic [7:0] expected_bytes[$];

    always #5 clock = ~clock;

    interrupt_acknowledge_sequencer dut (
        .clock                        (clock),
        .reset                        (reset),
        .write_initial_command_word_1 (write_initial_command_word_1),
        .interrupt_acknowledge_n      (interrupt_acknowledge_n),
        .u8086_or_mcs80_config        (u8086_or_mcs80_config),
        .interrupt                    (interrupt),
        .end_of_interrupt             (end_of_interrupt),
        .priority_rotate              (priority_rotate),
        .interrupt_vector_base        (interrupt_vector_base),
        .call_address_low             (call_address_low),
        .call_address_high            (call_address_high),
        .interrupt_to_cpu             (interrupt_to_cpu),
        .acknowledge_interrupt        (acknowledge_interrupt),
        .end_of_acknowledge_sequence  (end_of_acknowledge_sequence),
        .in_service_register          (in_service_register),
        .highest_level_in_service     (highest_level_in_service),
        .out_control_logic_data       (out_control_logic_data),
        .control_logic_data           (control_logic_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each new drive window pops one expected byte.
    always @(negedge clock) begin
        if (end_of_acknowledge_sequence) eoa_count++;
        if (out_control_logic_data && !drive_prev) begin
            drive_count++;
            if (expected_bytes.size() == 0) check_eq("unexpected_drive", control_logic_data, 32'h1ff);
            else                            check_eq("data_byte", control_logic_data, expected_bytes.pop_front());
        end
        if (!out_control_logic_data && control_logic_data != 8'h00)
            check_eq("idle_data_zero", control_logic_data, 8'h00);
        drive_prev = out_control_logic_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic inta_pulse(input int low_cycles);
        interrupt_acknowledge_n = 1'b0;
        tick(low_cycles);
        interrupt_acknowledge_n = 1'b1;
        tick(3);
    endtask

    task automatic clear_isr();
        end_of_interrupt = 8'hFF;
        tick(1);
        end_of_interrupt = 8'h00;
        tick(1);
    endtask

    initial begin
        int eoa_start;
        int drive_start;

        reset                        = 1'b1;
        write_initial_command_word_1 = 1'b0;
        interrupt_acknowledge_n      = 1'b1;
        u8086_or_mcs80_config        = 1'b1;
        interrupt                    = 8'h20;
        end_of_interrupt             = 8'h00;
        priority_rotate              = 3'd7;
        interrupt_vector_base        = 5'h10;
        call_address_low             = 3'b000;
        call_address_high            = 8'h00;
        tick(3);
        check_eq("rst_int_cpu", interrupt_to_cpu, 0);
        check_eq("rst_ack", acknowledge_interrupt, 8'h00);
        check_eq("rst_isr", in_service_register, 8'h00);
        check_eq("rst_eoa", end_of_acknowledge_sequence, 0);
        check_eq("rst_drive", out_control_logic_data, 0);
        check_eq("rst_data", control_logic_data, 8'h00);
        check_eq("rst_hlis", highest_level_in_service, 8'h00);
        interrupt = 8'h00;
        reset     = 1'b0;
        tick(2);

        // 8086 mode, level 3, vector base 0x10
        interrupt = 8'h08;
        tick(2);
        check_eq("int_cpu_raised", interrupt_to_cpu, 1);
        eoa_start = eoa_count;
        expected_bytes.push_back(8'h83);
        inta_pulse(2);
        check_eq("int_cpu_dropped", interrupt_to_cpu, 0);
        check_eq("ack_8086", acknowledge_interrupt, 8'h08);
        check_eq("isr_8086", in_service_register, 8'h08);
        interrupt = 8'h00;
        inta_pulse(2);
        check_eq("eoa_8086", eoa_count - eoa_start, 1);
        check_eq("drain_8086", expected_bytes.size(), 0);
        clear_isr();

        // MCS-80 mode CALL bytes
        u8086_or_mcs80_config = 1'b0;
        interrupt             = 8'h04;
        call_address_low      = 3'b101;
        call_address_high     = 8'h12;
        tick(2);
        eoa_start = eoa_count;
        expected_bytes.push_back(8'hCD);
        expected_bytes.push_back(8'hA8);
        expected_bytes.push_back(8'h12);
        inta_pulse(2);
        interrupt = 8'h00;
        inta_pulse(2);
        check_eq("eoa_mcs_mid", eoa_count - eoa_start, 0);
        inta_pulse(2);
        check_eq("eoa_mcs80", eoa_count - eoa_start, 1);
        check_eq("isr_mcs80", in_service_register, 8'h04);
        check_eq("drain_mcs80", expected_bytes.size(), 0);
        clear_isr();
        check_eq("hlis_empty", highest_level_in_service, 8'h00);

        // Build ISR = 0x81 for the rotation checks
        u8086_or_mcs80_config = 1'b1;
        interrupt             = 8'h01;
        tick(1);
        expected_bytes.push_back(8'h80);
        inta_pulse(2);
        inta_pulse(2);
        interrupt = 8'h80;
        tick(1);
        expected_bytes.push_back(8'h87);
        inta_pulse(2);
        inta_pulse(2);
        interrupt = 8'h00;
        tick(1);
        check_eq("isr_81", in_service_register, 8'h81);
        priority_rotate = 3'd6;
        #1;
        check_eq("hlis_rot6", highest_level_in_service, 8'h80);
        priority_rotate = 3'd7;
        #1;
        check_eq("hlis_rot7", highest_level_in_service, 8'h01);
        clear_isr();

        // EOI clearing the bit being set in the same cycle
        interrupt = 8'h08;
        tick(1);
        expected_bytes.push_back(8'h83);
        interrupt_acknowledge_n = 1'b0;
        end_of_interrupt        = 8'h08;
        tick(1);
        end_of_interrupt = 8'h00;
        check_eq("isr_clear_wins", in_service_register, 8'h00);
        check_eq("ack_clear_wins", acknowledge_interrupt, 8'h08);
        tick(1);
        interrupt_acknowledge_n = 1'b1;
        tick(3);
        interrupt = 8'h00;
        inta_pulse(2);
        check_eq("drain_clear_wins", expected_bytes.size(), 0);

        // ICW1 between pulses aborts the sequence
        interrupt = 8'h10;
        tick(1);
        eoa_start   = eoa_count;
        drive_start = drive_count;
        inta_pulse(2);
        write_initial_command_word_1 = 1'b1;
        tick(1);
        write_initial_command_word_1 = 1'b0;
        check_eq("icw1_int_cpu", interrupt_to_cpu, 0);
        check_eq("icw1_ack", acknowledge_interrupt, 8'h00);
        interrupt = 8'h20;
        tick(1);
        interrupt_acknowledge_n = 1'b0;
        tick(2);
        check_eq("icw1_no_drive", out_control_logic_data, 0);
        check_eq("icw1_restart_ack", acknowledge_interrupt, 8'h20);
        interrupt_acknowledge_n = 1'b1;
        write_initial_command_word_1 = 1'b1;
        tick(1);
        write_initial_command_word_1 = 1'b0;
        tick(3);
        check_eq("icw1_no_eoa", eoa_count - eoa_start, 0);
        check_eq("icw1_drive_count", drive_count - drive_start, 0);
        interrupt = 8'h00;
        clear_isr();

        // Reset mid-sequence
        interrupt = 8'h02;
        tick(1);
        eoa_start = eoa_count;
        inta_pulse(2);
        reset = 1'b1;
        tick(1);
        reset     = 1'b0;
        interrupt = 8'h00;
        check_eq("rst_mid_ack", acknowledge_interrupt, 8'h00);
        check_eq("rst_mid_isr", in_service_register, 8'h00);
        tick(3);
        check_eq("rst_mid_no_eoa", eoa_count - eoa_start, 0);

        // First INTA with no request
        interrupt   = 8'h00;
        eoa_start   = eoa_count;
        drive_start = drive_count;
`ifdef PIC_SPURIOUS_IRQ7_EN
        expected_bytes.push_back(8'h87);
        inta_pulse(2);
        inta_pulse(2);
        check_eq("spur_eoa", eoa_count - eoa_start, 1);
        check_eq("spur_isr", in_service_register, 8'h00);
        check_eq("spur_ack", acknowledge_interrupt, 8'h00);
        check_eq("spur_drive_count", drive_count - drive_start, 1);
`else
        inta_pulse(2);
        inta_pulse(2);
        check_eq("spur_eoa", eoa_count - eoa_start, 0);
        check_eq("spur_isr", in_service_register, 8'h00);
        check_eq("spur_drive_count", drive_count - drive_start, 0);
`endif
        check_eq("final_drain", expected_bytes.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
